// File: rtl/pattern_pkg.sv
// Shared defaults and index-width helpers for the pattern bank and its stores.
package pattern_pkg;

    localparam int DEF_NUM_BUFS  = 8;
    localparam int DEF_BUF_SIZE  = 22;
    localparam int DEF_BUF_WIDTH = 8;

    // Width of an index able to address n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pattern_store.sv
// One pattern store: serial shift load, byte write, combinational byte read
// and the whole store exposed as a flat vector (byte 0 in the LSBs).
module pattern_store
    import pattern_pkg::*;
#(
    parameter int BUF_SIZE  = DEF_BUF_SIZE,
    parameter int BUF_WIDTH = DEF_BUF_WIDTH,
    parameter int IW        = idx_w(BUF_SIZE),
    localparam int FW       = BUF_SIZE * BUF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_en,
    input  logic                 sin,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [BUF_WIDTH-1:0] wr_data,
    input  logic [IW-1:0]        rd_idx,
    output logic [BUF_WIDTH-1:0] rd_data,
    output logic [FW-1:0]        flat
);

    localparam logic [IW:0] SIZE = (IW+1)'(BUF_SIZE);

    // The bank never asserts wr_en and shift_en together, but the write is
    // still given priority so the store is safe on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flat <= '0;
        else if (wr_en)
            flat[int'(wr_idx)*BUF_WIDTH +: BUF_WIDTH] <= wr_data;
        else if (shift_en)
            flat <= {sin, flat[FW-1:1]};
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < SIZE)
            rd_data = flat[int'(rd_idx)*BUF_WIDTH +: BUF_WIDTH];
    end

endmodule

// File: rtl/pattern_bank.sv
// Bank of NUM_BUFS pattern stores with scan loading, field read/write and an
// active-store select that is protected against scan.
module pattern_bank
    import pattern_pkg::*;
#(
    parameter int NUM_BUFS  = DEF_NUM_BUFS,
    parameter int BUF_SIZE  = DEF_BUF_SIZE,
    parameter int BUF_WIDTH = DEF_BUF_WIDTH,
    parameter int AW        = idx_w(NUM_BUFS),
    parameter int IW        = idx_w(BUF_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ssel,
    input  logic                          sshift,
    input  logic [AW-1:0]                 saddr,
    input  logic                          sin,
    output logic                          sout,
    output logic                          scan_err,
    input  logic                          scan_err_clr,
    input  logic [AW-1:0]                 field_bufp,
    input  logic [IW-1:0]                 fieldp,
    input  logic                          field_rd,
    output logic [BUF_WIDTH-1:0]          field_byte,
    output logic                          field_valid,
    input  logic [IW-1:0]                 fieldwp,
    input  logic [BUF_WIDTH-1:0]          field_in,
    input  logic                          field_write,
    input  logic [AW-1:0]                 sel_next,
    input  logic                          sel_swap,
    output logic [AW-1:0]                 cur_sel,
    output logic [BUF_SIZE*BUF_WIDTH-1:0] current_buffer
);

    localparam int FW = BUF_SIZE * BUF_WIDTH;
    localparam logic [AW:0] NB = (AW+1)'(NUM_BUFS);
    localparam logic [IW:0] NS = (IW+1)'(BUF_SIZE);

    logic [NUM_BUFS-1:0][FW-1:0]        flat_all;
    logic [NUM_BUFS-1:0][BUF_WIDTH-1:0] rd_all;
    logic [NUM_BUFS-1:0]                lsb;

    logic saddr_ok, bufp_ok, wr_ok, scan_req, scan_blk;

    assign saddr_ok = {1'b0, saddr} < NB;
    assign bufp_ok  = {1'b0, field_bufp} < NB;
    assign wr_ok    = field_write && bufp_ok && ({1'b0, fieldwp} < NS);
    assign scan_req = ssel && sshift && saddr_ok;
    // A shift is refused when it targets the active store or collides with a
    // field write to the same store; either case flags a scan fault.
    assign scan_blk = (saddr == cur_sel) || (wr_ok && (field_bufp == saddr));

    for (genvar i = 0; i < NUM_BUFS; i++) begin : g_store
        pattern_store #(
            .BUF_SIZE  (BUF_SIZE),
            .BUF_WIDTH (BUF_WIDTH),
            .IW        (IW)
        ) u_store (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (scan_req && !scan_blk && (saddr == AW'(i))),
            .sin      (sin),
            .wr_en    (wr_ok && (field_bufp == AW'(i))),
            .wr_idx   (fieldwp),
            .wr_data  (field_in),
            .rd_idx   (fieldp),
            .rd_data  (rd_all[i]),
            .flat     (flat_all[i])
        );
        assign lsb[i] = flat_all[i][0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout        <= 1'b0;
            scan_err    <= 1'b0;
            field_byte  <= '0;
            field_valid <= 1'b0;
            cur_sel     <= '0;
        end else begin
            sout <= (ssel && saddr_ok) ? lsb[saddr] : 1'b0;

            if (scan_req && scan_blk)
                scan_err <= 1'b1;
            else if (scan_err_clr)
                scan_err <= 1'b0;

            field_valid <= field_rd;
            if (field_rd)
                field_byte <= bufp_ok ? rd_all[field_bufp] : '0;

            if (sel_swap && ({1'b0, sel_next} < NB))
                cur_sel <= sel_next;
        end
    end

    assign current_buffer = flat_all[cur_sel];

endmodule

// File: tb/tb_pattern_bank.sv
// Directed bench for pattern_bank: byte-level reference model compared every
// cycle, plus hand-computed literal checks at the interesting points.
module tb_pattern_bank;

    localparam int NB = 6;
    localparam int BS = 22;
    localparam int BW = 8;
    localparam int AW = 3;
    localparam int IW = 5;
    localparam int FW = BS * BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ssel, sshift, sin, scan_err_clr, field_rd, field_write, sel_swap;
    logic [AW-1:0] saddr, field_bufp, sel_next;
    logic [IW-1:0] fieldp, fieldwp;
    logic [BW-1:0] field_in;
    logic sout, scan_err, field_valid;
    logic [BW-1:0] field_byte;
    logic [AW-1:0] cur_sel;
    logic [FW-1:0] current_buffer;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pattern_bank #(.NUM_BUFS(NB), .BUF_SIZE(BS), .BUF_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ssel(ssel), .sshift(sshift), .saddr(saddr), .sin(sin),
        .sout(sout), .scan_err(scan_err), .scan_err_clr(scan_err_clr),
        .field_bufp(field_bufp), .fieldp(fieldp), .field_rd(field_rd),
        .field_byte(field_byte), .field_valid(field_valid),
        .fieldwp(fieldwp), .field_in(field_in), .field_write(field_write),
        .sel_next(sel_next), .sel_swap(sel_swap),
        .cur_sel(cur_sel), .current_buffer(current_buffer)
    );

    // ---------------- reference model ----------------
    logic [7:0] mem [NB][BS];
    int         m_cur;
    logic       m_sout, m_err, m_fv;
    logic [7:0] m_fb;
    logic       wr_ok, att, blk, c, nc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NB; s++)
                for (int b = 0; b < BS; b++) mem[s][b] = 8'h00;
            m_cur = 0; m_sout = 0; m_err = 0; m_fv = 0; m_fb = 8'h00;
        end else begin
            wr_ok = field_write && (int'(field_bufp) < NB) && (int'(fieldwp) < BS);
            m_fv = field_rd;
            if (field_rd)
                m_fb = (int'(field_bufp) < NB && int'(fieldp) < BS) ? mem[field_bufp][fieldp] : 8'h00;
            m_sout = (ssel && int'(saddr) < NB) ? mem[saddr][0][0] : 1'b0;
            att = ssel && sshift && (int'(saddr) < NB);
            blk = (int'(saddr) == m_cur) || (wr_ok && field_bufp == saddr);
            if (att && blk) m_err = 1'b1;
            else if (scan_err_clr) m_err = 1'b0;
            if (att && !blk) begin
                c = sin;
                for (int b = BS - 1; b >= 0; b--) begin
                    nc = mem[saddr][b][0];
                    mem[saddr][b] = {c, mem[saddr][b][7:1]};
                    c = nc;
                end
            end
            if (wr_ok) mem[field_bufp][fieldwp] = field_in;
            if (sel_swap && int'(sel_next) < NB) m_cur = int'(sel_next);
        end
    end

    function automatic logic [FW-1:0] exp_flat();
        logic [FW-1:0] f;
        for (int b = 0; b < BS; b++) f[b*BW +: BW] = mem[m_cur][b];
        return f;
    endfunction

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cur_sel", FW'(cur_sel), FW'(m_cur));
            chk("sout", FW'(sout), FW'(m_sout));
            chk("scan_err", FW'(scan_err), FW'(m_err));
            chk("field_valid", FW'(field_valid), FW'(m_fv));
            chk("field_byte", FW'(field_byte), FW'(m_fb));
            chk("current_buffer", current_buffer, exp_flat());
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ssel = 0; sshift = 0; sin = 0; scan_err_clr = 0;
        field_rd = 0; field_write = 0; sel_swap = 0;
    endtask

    task automatic swap_to(input int s);
        sel_next = AW'(s); sel_swap = 1; cyc(); sel_swap = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sout"}, FW'(sout), '0);
        chk({tag, "_err"}, FW'(scan_err), '0);
        chk({tag, "_fv"}, FW'(field_valid), '0);
        chk({tag, "_fb"}, FW'(field_byte), '0);
        chk({tag, "_cur"}, FW'(cur_sel), '0);
        chk({tag, "_buf"}, current_buffer, '0);
    endtask

    logic [7:0]    bv;
    logic [7:0]    pat01 = 8'h01;
    logic [FW-1:0] load_img = 176'h161514131211100f0e0d0c0b0a090807060504030201;

    initial begin
        idle();
        saddr = '0; field_bufp = '0; sel_next = '0;
        fieldp = '0; fieldwp = '0; field_in = '0;
        cyc(); cyc();
        chk_all_zero("por");
        rst_n = 1;

        // reset mid-shift, with live read data and a written byte
        field_bufp = 1; fieldwp = 0; field_in = 8'h77; field_write = 1; cyc();
        field_write = 0; field_rd = 1; fieldp = 0; cyc();
        chk("pre_rst_fb", FW'(field_byte), FW'(8'h77));
        field_rd = 0;
        ssel = 1; sshift = 1; saddr = 1; sin = 1;
        repeat (10) cyc();
        #2 rst_n = 0;
        #1 chk_all_zero("midrst");
        idle();
        cyc();
        rst_n = 1;
        for (int s = 0; s < NB; s++) begin
            swap_to(s);
            chk("rst_sel", FW'(cur_sel), FW'(s));
            chk("rst_buf", current_buffer, '0);
        end
        swap_to(0);

        // full scan load of store 2, byte k = k+1, LSB first
        ssel = 1; sshift = 1; saddr = 2;
        for (int k = 0; k < FW; k++) begin
            bv = 8'(k / 8 + 1);
            sin = bv[k % 8];
            cyc();
        end
        idle();
        swap_to(2);
        chk("load_img", current_buffer, load_img);
        swap_to(0);

        // further shifts read byte 0 out LSB first
        ssel = 1; sshift = 1; saddr = 2; sin = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("sout_bit", FW'(sout), FW'(pat01[k]));
        end
        idle();

        // active-store protection
        field_bufp = 3; fieldwp = 0; field_in = 8'h3E; field_write = 1; cyc();
        field_write = 0;
        swap_to(3);
        ssel = 1; sshift = 1; saddr = 3; sin = 1;
        repeat (4) cyc();
        idle();
        chk("prot_err", FW'(scan_err), FW'(1));
        chk("prot_buf", current_buffer, FW'(8'h3E));
        scan_err_clr = 1; cyc(); scan_err_clr = 0;
        chk("err_clr", FW'(scan_err), '0);

        // field write / read path
        field_bufp = 5; fieldwp = 21; field_in = 8'hA5; field_write = 1; cyc();
        field_write = 0; fieldp = 21; field_rd = 1; cyc();
        chk("rd_a5", FW'(field_byte), FW'(8'hA5));
        chk("rd_vld", FW'(field_valid), FW'(1));
        field_in = 8'h3C; field_write = 1; cyc();
        chk("rd_prewrite", FW'(field_byte), FW'(8'hA5));
        field_write = 0; field_rd = 0; cyc();
        chk("rd_idle_vld", FW'(field_valid), '0);
        chk("rd_hold", FW'(field_byte), FW'(8'hA5));
        field_rd = 1; cyc(); field_rd = 0;
        chk("rd_3c", FW'(field_byte), FW'(8'h3C));

        // bounds: dropped writes, ignored swap, ignored scan, zero reads
        field_bufp = 0; fieldwp = 22; field_in = 8'hFF; field_write = 1; cyc();
        field_bufp = 7; fieldwp = 0; cyc();
        field_write = 0;
        swap_to(7);
        chk("oob_swap", FW'(cur_sel), FW'(3));
        ssel = 1; sshift = 1; saddr = 6; sin = 1; cyc();
        idle();
        chk("oob_scan_err", FW'(scan_err), '0);
        chk("oob_sout", FW'(sout), '0);
        field_bufp = 5; fieldp = 22; field_rd = 1; cyc();
        chk("oob_rd_fb", FW'(field_byte), '0);
        chk("oob_rd_vld", FW'(field_valid), FW'(1));
        field_bufp = 6; fieldp = 0; cyc(); field_rd = 0;
        chk("oob_bufp_fb", FW'(field_byte), '0);
        swap_to(0);
        chk("oob_store0", current_buffer, '0);

        // write and shift to the same store in one cycle
        field_bufp = 1; fieldwp = 3; field_in = 8'h5A; field_write = 1;
        ssel = 1; sshift = 1; saddr = 1; sin = 1; cyc();
        idle();
        chk("coll_err", FW'(scan_err), FW'(1));
        swap_to(1);
        chk("coll_buf", current_buffer, FW'(32'h5A00_0000));

        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
